// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Purpose  : IF stage of the 5-stage MIPS pipeline. Owns the PC, drives the
//            instruction memory address, registers the IF/ID outputs and
//            holds a direct-mapped table of 2-bit saturating counters (BHT)
//            that predicts beq in IF. j/jal are redirected in IF, and
//            mispredicts reported by decode are recovered through
//            PredictMiss/PCbranched.
// Ports    : clk          pipeline clock, all state on posedge
//            rst          asynchronous active-low reset
//            stall        hazard-unit hold of PC and IF/ID
//            PredictMiss  branch now in ID was mispredicted
//            PCbranched   correct-path PC from decode (valid on PredictMiss)
//            ID_Branch    control-unit Branch for the instruction in ID
//            IM_addr      instruction memory address (= PC)
//            IM_data      instruction word, combinational read of IM_addr
//            PCadd4       IF/ID: PC+4 of the instruction in ID
//            Instruction  IF/ID: instruction in ID, 0 = bubble
//            BranchTaken  IF/ID: IF prediction for the instruction in ID
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int          BHT_IDX_W = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [1:0]  BHT_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PredictMiss,
  input  logic [31:0] PCbranched,
  input  logic        ID_Branch,
  output logic [31:0] IM_addr,
  input  logic [31:0] IM_data,
  output logic [31:0] PCadd4,
  output logic [31:0] Instruction,
  output logic        BranchTaken
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_JAL = 6'd3;
  localparam logic [5:0] OP_BEQ = 6'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] pc_q,      pc_d;
  logic [31:0] pcadd4_q,  pcadd4_d;
  logic [31:0] instr_q,   instr_d;
  logic        btaken_q,  btaken_d;
  logic [1:0]  bht_q [BHT_N];
  logic [1:0]  bht_d [BHT_N];

  // --------------------------------------------------------------------------
  // Pre-decode of the word currently being fetched
  // --------------------------------------------------------------------------
  logic [5:0]           opcode;
  logic                 pd_beq;
  logic                 pd_jmp;
  logic [31:0]          pc4;
  logic [31:0]          br_off;
  logic [31:0]          br_tgt;
  logic [31:0]          j_tgt;
  logic [BHT_IDX_W-1:0] lookup_idx;
  logic                 pred_t;

  assign opcode     = IM_data[31:26];
  assign pd_beq     = (opcode == OP_BEQ);
  assign pd_jmp     = (opcode == OP_J) || (opcode == OP_JAL);
  assign pc4        = pc_q + 32'd4;
  assign br_off     = {{14{IM_data[15]}}, IM_data[15:0], 2'b00};
  assign br_tgt     = pc4 + br_off;
  assign j_tgt      = {pc4[31:28], IM_data[25:0], 2'b00};
  assign lookup_idx = pc_q[BHT_IDX_W+1:2];
  // Lookup reads the registered table, so a same-cycle update of the same
  // entry is not visible until after the edge.
  assign pred_t     = pd_beq && bht_q[lookup_idx][1];

  // --------------------------------------------------------------------------
  // Counter training from the branch resolved in ID
  // --------------------------------------------------------------------------
  logic [31:0]          id_pc;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 upd_en;
  logic                 actual_taken;
  logic [1:0]           cnt_cur;
  logic [1:0]           cnt_new;

  assign id_pc        = pcadd4_q - 32'd4;
  assign upd_idx      = id_pc[BHT_IDX_W+1:2];
  assign upd_en       = !stall && ID_Branch && (instr_q != 32'd0);
  // A miss means the real outcome is the opposite of what IF guessed.
  assign actual_taken = btaken_q ^ PredictMiss;
  assign cnt_cur      = bht_q[upd_idx];

  always_comb begin
    cnt_new = cnt_cur;
    if (actual_taken) begin
      if (cnt_cur != 2'b11) cnt_new = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_new = cnt_cur - 2'b01;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (upd_en) bht_d[upd_idx] = cnt_new;
  end

  // --------------------------------------------------------------------------
  // Next PC and IF/ID register
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    pcadd4_d = pcadd4_q;
    instr_d  = instr_q;
    btaken_d = btaken_q;
    // During a stall decode keeps PredictMiss asserted and re-presents it
    // afterwards, so nothing is acted on here until the stall drops.
    if (!stall) begin
      pcadd4_d = pc4;
      if (PredictMiss) begin
        // Squash the wrong-path word in IF.
        pc_d     = PCbranched;
        instr_d  = 32'd0;
        btaken_d = 1'b0;
      end else if (pd_jmp) begin
        pc_d     = j_tgt;
        instr_d  = IM_data;
        btaken_d = 1'b0;
      end else if (pred_t) begin
        pc_d     = br_tgt;
        instr_d  = IM_data;
        btaken_d = 1'b1;
      end else begin
        pc_d     = pc4;
        instr_d  = IM_data;
        btaken_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      pcadd4_q <= 32'd0;
      instr_q  <= 32'd0;
      btaken_q <= 1'b0;
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= BHT_INIT;
      end
    end else begin
      pc_q     <= pc_d;
      pcadd4_q <= pcadd4_d;
      instr_q  <= instr_d;
      btaken_q <= btaken_d;
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign IM_addr     = pc_q;
  assign PCadd4      = pcadd4_q;
  assign Instruction = instr_q;
  assign BranchTaken = btaken_q;

endmodule

`default_nettype wire
